// File: rtl/derived_clock_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// derived_clock_ctrl_pkg : shared types and constants for the derived clock
// Revision: 1.0
// ---------------------------------------------------------------------------
package derived_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } dcc_state_t;

  localparam int unsigned DCC_DEFAULT_N = 0;

  function automatic int unsigned dcc_idw(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/derived_clock_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// derived_clock_core : divider counter, toggle strobe and stop-low gating
// Revision: 1.0
// ---------------------------------------------------------------------------
module derived_clock_core #(
  parameter int unsigned CW     = 32,
  parameter int unsigned DIVIDE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [CW-1:0] n,
  output logic          out_clk,
  output logic          tick,
  output logic          fall_next,
  output logic          stopped
);

  localparam logic [2:0] DIV = 3'(DIVIDE);

  logic [CW-1:0] count;
  logic [2:0]    dcnt;
  logic          at_rest;
  logic          run;
  logic          count_wrap;
  logic          phase_end;

  // The rest state is exactly what a falling boundary leaves behind, so
  // stopping there needs no extra flag.
  assign at_rest    = !out_clk && (count == '0) && (dcnt == 3'd0);
  assign stopped    = !enable && at_rest;
  assign run        = !stopped;
  assign count_wrap = !(count < n);
  assign phase_end  = count_wrap && !(dcnt < DIV);
  assign fall_next  = run && phase_end && out_clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      dcnt    <= 3'd0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (run) begin
        if (!count_wrap) begin
          count <= count + CW'(1);
        end else begin
          count <= '0;
          if (dcnt < DIV) begin
            dcnt <= dcnt + 3'd1;
          end else begin
            dcnt    <= 3'd0;
            out_clk <= ~out_clk;
            tick    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/derived_clock_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// derived_clock_ctrl : shared divider with round-robin glitch-free retuning
// Revision: 1.0
// ---------------------------------------------------------------------------
module derived_clock_ctrl
  import derived_clock_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned CW        = 32,
  parameter int unsigned DIVIDE    = 2,
  parameter int unsigned DEFAULT_N = DCC_DEFAULT_N,
  localparam int unsigned IDW      = dcc_idw(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*CW-1:0] req_n,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_clk,
  output logic               tick,
  output logic [CW-1:0]      cur_n,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
);

  dcc_state_t      state;
  dcc_state_t      state_nxt;
  logic [CW-1:0]   pending;
  logic [IDW-1:0]  rr_ptr;
  logic            grant_hit;
  logic [IDW-1:0]  grant_idx;
  logic [CW-1:0]   grant_n;
  logic            take;
  logic [CW-1:0]   core_n;
  logic            core_fall;
  logic            core_stopped;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int unsigned idx;
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_hit && req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_n = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) grant_n = req_n[k*CW +: CW];
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (grant_hit && rst_n) begin
          take      = 1'b1;
          req_ready = NREQ'(1) << grant_idx;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (core_fall || core_stopped) state_nxt = ST_APPLY;
      end
      ST_APPLY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pending  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      busy     <= 1'b0;
      cur_n    <= CW'(DEFAULT_N);
    end else begin
      state <= state_nxt;
      if (take) begin
        pending  <= grant_n;
        grant_id <= grant_idx;
        rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        busy     <= 1'b1;
      end
      if (state == ST_APPLY) begin
        cur_n <= pending;
        busy  <= 1'b0;
      end
    end
  end

  // The APPLY cycle sits at the rest state; steering the new N into the
  // core there makes the whole following low phase use it.
  assign core_n = (state == ST_APPLY) ? pending : cur_n;

  derived_clock_core #(
    .CW     (CW),
    .DIVIDE (DIVIDE)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .n         (core_n),
    .out_clk   (out_clk),
    .tick      (tick),
    .fall_next (core_fall),
    .stopped   (core_stopped)
  );

endmodule
`default_nettype wire

// File: tb/tb_derived_clock_ctrl.sv
`default_nettype none
// Bench for derived_clock_ctrl: directed retune vectors plus gating/reset sequences.
module tb_derived_clock_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DEFAULT_N=1, DIVIDE=2
  logic        rst_n, enable;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_n;
  logic        out_clk, tick, busy;
  logic [31:0] cur_n;
  logic [0:0]  grant_id;

  // Second instance: DEFAULT_N=0, DIVIDE=0
  logic        rst0_n, enable0;
  logic [1:0]  req_valid0, req_ready0;
  logic [63:0] req_n0;
  logic        out_clk0, tick0, busy0;
  logic [31:0] cur_n0;
  logic [0:0]  grant_id0;

  derived_clock_ctrl #(.NREQ(2), .CW(32), .DIVIDE(2), .DEFAULT_N(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .out_clk(out_clk), .tick(tick), .cur_n(cur_n),
    .busy(busy), .grant_id(grant_id));

  derived_clock_ctrl #(.NREQ(2), .CW(32), .DIVIDE(0), .DEFAULT_N(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .enable(enable0), .req_valid(req_valid0), .req_n(req_n0),
    .req_ready(req_ready0), .out_clk(out_clk0), .tick(tick0), .cur_n(cur_n0),
    .busy(busy0), .grant_id(grant_id0));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] n;
    logic [1:0]  exp_ready;
    int          exp_half;
  } retune_t;

  retune_t vec[5];

  task automatic wait_busy_low(input string name);
    int k = 0;
    while (busy && k < 300) begin cyc(); k++; end
    check(name, k < 300, 1);
  endtask

  task automatic run_retune(input int idx, input logic [31:0] n,
                            input logic [1:0] exp_ready, input int exp_half);
    int k;
    int c;
    bit last_fall;
    k = 0;
    while (!(out_clk && !tick) && k < 100) begin cyc(); k++; end
    check("mid_high_reached", k < 100, 1);
    req_n[idx*32 +: 32] = n;
    req_valid = 2'b00;
    req_valid[idx] = 1'b1;
    #1;
    check("req_ready", req_ready, exp_ready);
    cyc();
    req_valid = 2'b00;
    check("busy_after_grant", busy, 1);
    check("grant_id", grant_id, idx);
    k = 0;
    last_fall = 0;
    while (busy && k < 300) begin
      last_fall = tick && !out_clk;
      cyc();
      k++;
    end
    check("busy_released", k < 300, 1);
    check("apply_at_falling_boundary", last_fall, 1);
    check("cur_n_applied", cur_n, n);
    check("out_clk_low_after_apply", out_clk, 0);
    c = 1;
    while (!tick && c < 300) begin cyc(); c++; end
    check("low_half_period", c, exp_half);
    check("rise_after_low", out_clk, 1);
    c = 0;
    do begin cyc(); c++; end while (!tick && c < 300);
    check("high_half_period", c, exp_half);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, errs_t, errs_c, bc, gap, c;
    bit last_fall;
    logic prev;

    rst_n = 0; enable = 1; req_valid = 2'b11; req_n = '0;
    rst0_n = 0; enable0 = 1; req_valid0 = 2'b00; req_n0 = '0;
    repeat (3) cyc();
    #1;
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_out_clk", out_clk, 0);
    check("reset_tick", tick, 0);
    check("reset_busy", busy, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_cur_n", cur_n, 1);
    req_valid = 2'b00;
    rst_n = 1; rst0_n = 1;

    // Free-running period with DEFAULT_N=1, DIVIDE=2: half period 6
    k = 0;
    do begin cyc(); k++; end while (!tick && k < 50);
    check("first_tick_cycle", k, 6);
    check("first_tick_out_clk", out_clk, 1);
    errs_t = 0; errs_c = 0;
    for (int j = 1; j <= 24; j++) begin
      cyc();
      if (tick !== (j % 6 == 0)) errs_t++;
      if (out_clk !== (((6 + j) / 6) % 2 == 1)) errs_c++;
    end
    check("steady_tick_pattern", errs_t, 0);
    check("steady_clk_pattern", errs_c, 0);
    check("steady_cur_n", cur_n, 1);
    check("steady_busy", busy, 0);

    // Retune vectors: half period = (N+1)*3
    vec[0] = '{0, 32'd3, 2'b01, 12};
    vec[1] = '{1, 32'd0, 2'b10, 3};
    vec[2] = '{0, 32'd1, 2'b01, 6};
    vec[3] = '{1, 32'd5, 2'b10, 18};
    vec[4] = '{0, 32'd5, 2'b01, 18};
    for (int v = 0; v < 5; v++) run_retune(vec[v].idx, vec[v].n, vec[v].exp_ready, vec[v].exp_half);

    // Stop with a request pending
    k = 0;
    while (!(out_clk && !tick) && k < 100) begin cyc(); k++; end
    req_n[63:32] = 32'd2; req_valid = 2'b10; enable = 0;
    #1;
    check("gate_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    wait_busy_low("gate_busy_released");
    check("gate_cur_n", cur_n, 2);
    check("gate_out_clk_low", out_clk, 0);
    bc = 0;
    repeat (10) begin cyc(); if (tick || out_clk) bc++; end
    check("stopped_quiet", bc, 0);

    // Request while stopped applies without waiting for a boundary
    req_n[31:0] = 32'd1; req_valid = 2'b01;
    #1;
    check("stopped_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    bc = 0;
    while (busy && bc < 20) begin bc++; cyc(); end
    check("stopped_busy_cycles", bc, 2);
    check("stopped_cur_n", cur_n, 1);
    enable = 1;
    k = 0;
    do begin cyc(); k++; end while (!tick && k < 50);
    check("restart_first_tick", k, 6);
    check("restart_out_clk", out_clk, 1);

    // Two simultaneous requests after reset
    rst_n = 0;
    cyc(); cyc();
    check("reset2_out_clk", out_clk, 0);
    check("reset2_cur_n", cur_n, 1);
    check("reset2_busy", busy, 0);
    rst_n = 1;
    req_n = {32'd5, 32'd4}; req_valid = 2'b11;
    #1;
    check("dual_first_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10;
    check("dual_first_grant_id", grant_id, 0);
    check("dual_first_busy", busy, 1);
    gap = 1;
    while (!req_ready[1] && gap < 300) begin cyc(); gap++; end
    check("dual_grant_spacing", gap >= 3 && gap < 300, 1);
    check("dual_mid_cur_n", cur_n, 4);
    check("dual_mid_busy", busy, 0);
    cyc();
    req_valid = 2'b00;
    check("dual_second_grant_id", grant_id, 1);
    wait_busy_low("dual_busy_released");
    check("dual_final_cur_n", cur_n, 5);

    // Reset during PEND discards the pending value and the RR pointer
    req_n[31:0] = 32'd7; req_valid = 2'b01;
    #1;
    check("pend_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    check("pend_busy", busy, 1);
    rst_n = 0;
    cyc();
    check("pend_reset_busy", busy, 0);
    check("pend_reset_cur_n", cur_n, 1);
    check("pend_reset_out_clk", out_clk, 0);
    rst_n = 1;
    repeat (30) cyc();
    check("pend_discarded_cur_n", cur_n, 1);
    check("pend_discarded_busy", busy, 0);
    req_n = {32'd6, 32'd2}; req_valid = 2'b11;
    #1;
    check("rr_ptr_reset_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    wait_busy_low("rr_busy_released");
    check("rr_cur_n", cur_n, 2);

    // N=0, DIVIDE=0 instance: toggles every cycle, retune only at a fall
    errs_t = 0;
    prev = out_clk0;
    repeat (6) begin
      cyc();
      if (!tick0) errs_t++;
      if (out_clk0 === prev) errs_t++;
      prev = out_clk0;
    end
    check("n0_toggle_every_cycle", errs_t, 0);
    check("n0_cur_n", cur_n0, 0);
    req_n0[31:0] = 32'd2; req_valid0 = 2'b01;
    #1;
    check("n0_req_ready", req_ready0, 2'b01);
    cyc();
    req_valid0 = 2'b00;
    check("n0_busy", busy0, 1);
    k = 0; last_fall = 0;
    while (busy0 && k < 50) begin last_fall = tick0 && !out_clk0; cyc(); k++; end
    check("n0_busy_released", k < 50, 1);
    check("n0_apply_at_fall", last_fall, 1);
    check("n0_cur_n_applied", cur_n0, 2);
    check("n0_out_clk_low", out_clk0, 0);
    c = 1;
    while (!tick0 && c < 50) begin cyc(); c++; end
    check("n0_new_low_half", c, 3);
    check("n0_rise", out_clk0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/derived_clock_ctrl.md
Name: derived_clock_ctrl

Overview:
Owns one programmable clock divider and shares its configuration between NREQ requesters (e.g. the register bank and the sweep sequencer). Requests to retune the divider are arbitrated round-robin and applied only at a falling-edge phase boundary of the derived clock, so the derived clock never glitches and never produces a runt phase. It also provides start/stop gating and a per-toggle tick strobe for downstream logic.

Parameters:
NREQ, 2, number of requesters (1..8)
CW, 32, width of divider count N
DIVIDE, 2, extra sub-phases per half period (3-bit, 0..7)
DEFAULT_N, 0, cur_n value after reset

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset; clock clk
enable  in  1  run/stop gate for the derived clock
req_valid  in  NREQ  per-requester retune request
req_n  in  NREQ*CW  requested N, requester i in bits [i*CW +: CW]
req_ready  out  NREQ  one-hot accept strobe, high for one cycle on grant
out_clk  out  1  derived clock
tick  out  1  one-cycle strobe on the cycle out_clk toggles
cur_n  out  CW  N currently in use by the divider
busy  out  1  high while a granted request is pending
grant_id  out  max(1,clog2(NREQ))  index of the last granted requester

Behaviour:
- Reset (rst_n=0 at posedge): out_clk=0, tick=0, req_ready=0, busy=0, grant_id=0, cur_n=DEFAULT_N, count=0, dcnt=0, RR pointer=0, FSM=IDLE. Any pending request is discarded and is not re-presented.
- Divider core, when running: if count<cur_n then count++. Else (count==cur_n) count=0, and:
  - if dcnt<DIVIDE: dcnt++;
  - else: dcnt=0, out_clk toggles, tick=1 for that cycle.
- Half period = (cur_n+1)*(DIVIDE+1) cycles. A "falling boundary" is a toggle cycle with out_clk 1->0.
- Gating: enable=0 lets the core run to the next falling boundary, then it stops with out_clk=0, count=0, dcnt=0. enable=1 restarts counting from that state on the next cycle. The first rising toggle comes one half period later.
- FSM states: IDLE, PEND, APPLY.
  - IDLE: if any req_valid, grant the first set bit at or after the RR pointer. That cycle: req_ready[i]=1, pending<=req_n[i], grant_id<=i, RR pointer<=i+1 mod NREQ, busy<=1. Go to PEND.
  - PEND: on a falling-boundary cycle, or any cycle where the core is stopped, go to APPLY.
  - APPLY: cur_n<=pending, busy<=0, go to IDLE. The new N governs counting from the cycle after APPLY. Because the core is at count=0, dcnt=0, out_clk=0, the low phase that follows uses the new N in full.
- Requests during PEND/APPLY are not accepted (req_ready=0). The requester holds req_valid.
- Minimum spacing between two grants is 3 cycles.
- A request with N equal to cur_n is processed normally.
- N=0 is legal: half period is DIVIDE+1 cycles.
- Arithmetic: count is CW bits and unsigned. count never exceeds cur_n because N changes only when count=0.
- Simultaneous events:
  - A tick and a grant in the same cycle are both honoured.
  - If enable falls while in PEND, the request is applied at the stop boundary.
  - rst_n overrides everything.

Decomposition:
- Shared package: FSM state encoding (IDLE/PEND/APPLY), the IDW width function max(1,clog2(NREQ)), and the DEFAULT_N constant.
- One sub-module, derived_clock_core: count/dcnt/out_clk/tick, stop-at-falling-boundary gating, and a boundary/stopped status output.
- The arbiter and FSM stay in the top module.

Test Plan:
- Reset, DEFAULT_N=1, DIVIDE=2, enable=1 -> first tick at cycle 6 after reset release; tick every 6 cycles; out_clk period 12; cur_n=1; busy=0.
- req_valid[0] with req_n=3, asserted mid high phase -> req_ready[0] pulses 1 cycle; busy held until the falling boundary; cur_n=3 one cycle later; subsequent half periods are 12 cycles; no short phase.
- req_valid[0]=N 4 and req_valid[1]=N 5 in the same cycle after reset -> req0 granted first (grant_id=0), req1 granted ≥3 cycles after the first grant and after APPLY (grant_id=1); final cur_n=5.
- enable=0 with a request pending -> core stops at the falling boundary with out_clk=0; APPLY occurs the next cycle; enable=1 -> first tick after (N+1)*(DIVIDE+1) cycles with the new N.
- rst_n pulsed low while in PEND -> pending request discarded; cur_n=DEFAULT_N; out_clk=0; busy=0; RR pointer back to 0.
- N=0, DIVIDE=0 -> tick every cycle; out_clk toggles every cycle; a retune request still applies only at a falling boundary.
